rare_node_monitor: RTL and testbench
====================================

RARE_NODE_MONITOR -- requirements
Module: rare_node_monitor

Interface
REQ-001 NODE_W, 16, number of observed circuit nodes (1..256).
REQ-002 CNT_W, 16, per-node counter width; WINDOW SHALL be < 2**CNT_W.
REQ-003 WINDOW, 1024, valid samples per observation window (>=1).
REQ-004 THRESH, 8, rarity threshold; a node is rare when its minority-value count < THRESH.
REQ-005 CK  input  1  clock, all state updates on rising edge.
REQ-006 RST  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  single-cycle request to begin a window; honoured only in IDLE.
REQ-008 node_valid  input  1  nodes carries a sample this cycle.
REQ-009 nodes  input  NODE_W  sampled node values from the circuit under test.
REQ-010 busy  output  1  high in RUN and SCAN.
REQ-011 rpt_valid  output  1  one node report per cycle during SCAN.
REQ-012 rpt_idx  output  clog2(NODE_W) (min 1)  node index of current report.
REQ-013 rpt_rare  output  1  current node is rare.
REQ-014 rpt_ones  output  CNT_W  ones count of current node.
REQ-015 rare_total  output  clog2(NODE_W+1)  rare nodes found in last completed window.
REQ-016 done  output  1  one-cycle pulse when SCAN completes.

Function
REQ-017 FSM states IDLE, RUN, SCAN, DONE; IDLE->RUN on start, RUN->SCAN after the WINDOW-th accepted sample, SCAN->DONE after index NODE_W-1 reported, DONE->IDLE unconditionally next cycle.
REQ-018 Entering RUN clears all per-node counters, the sample counter and the running rare count; rare_total holds the previous result until DONE.
REQ-019 In RUN each cycle with node_valid=1 increments sample counter and, for every i with nodes[i]=1, ones[i] by 1; node_valid=0 changes nothing.
REQ-020 node_valid outside RUN, and start outside IDLE, SHALL be ignored.
REQ-021 The sample on which the count reaches WINDOW is counted; transition to SCAN occurs on that same edge.
REQ-022 SCAN reports index 0..NODE_W-1 in ascending order, one per cycle, rpt_valid=1 each cycle, no stalls; report latency for index k is k+1 cycles after RUN exit.
REQ-023 rpt_rare = (min(ones[i], WINDOW-ones[i]) < THRESH); computed at width CNT_W+1, no overflow.
REQ-024 On entering DONE, rare_total SHALL equal the number of reported rpt_rare=1; done=1 for exactly that one cycle.
REQ-025 busy=1 exactly while state is RUN or SCAN.
REQ-026 rpt_idx, rpt_rare, rpt_ones SHALL be 0 whenever rpt_valid=0.

Reset
REQ-027 RST=1 immediately forces IDLE and zeroes all counters and outputs (busy, rpt_*, rare_total, done), including mid-RUN or mid-SCAN; no partial report survives.
REQ-028 First start is accepted on the first rising edge after RST deasserts.

Configuration
REQ-029 Macro RARE_TOGGLE_CNT_EN: when defined, per-node toggle counters (CNT_W) count cycles in RUN where nodes[i] differs from the previous valid sample (first sample of window never counts), output rpt_tog (CNT_W) is added, and rpt_rare additionally asserts when tog[i] < THRESH.
REQ-030 Without RARE_TOGGLE_CNT_EN no toggle storage, no rpt_tog port, rarity per REQ-023 only.

Verification (NODE_W=4, WINDOW=16, THRESH=2)
REQ-031 nodes=4'b0001 for 16 valid samples -> reports ones={16,0,0,0}, rpt_rare={1,1,1,1}, rare_total=4, done 5 cycles after last sample.
REQ-032 node0 alternates 0/1, node1 high on 1 sample, node2 high on 2, node3 low on 1 -> rpt_rare={0,1,0,1}, rare_total=2.
REQ-033 node_valid toggled every other cycle over 32 cycles -> SCAN entered only after the 16th valid sample, counts unchanged vs. REQ-032 stream.
REQ-034 RST pulsed after 10 samples in RUN -> all outputs 0 asynchronously, state IDLE; new start then yields clean window results.
REQ-035 start pulsed during RUN and SCAN -> ignored, single done pulse, rare_total unchanged until DONE.
REQ-036 With RARE_TOGGLE_CNT_EN, node0 alternating for 16 samples -> rpt_tog=15, rare=0; constant node -> rpt_tog=0, rare=1.

Source files
------------

// File: rtl/rare_node_monitor_if.sv
// Bundles the monitor's control, sample and report signals; master drives samples, slave is the monitor.
// rpt_tog is present only when RARE_TOGGLE_CNT_EN is defined.
interface rare_node_monitor_if #(
  parameter int NODE_W = 16,
  parameter int CNT_W  = 16
);
  localparam int IDX_W = (NODE_W > 1) ? $clog2(NODE_W) : 1;
  localparam int TOT_W = $clog2(NODE_W + 1);

  logic              start;
  logic              node_valid;
  logic [NODE_W-1:0] nodes;
  logic              busy;
  logic              rpt_valid;
  logic [IDX_W-1:0]  rpt_idx;
  logic              rpt_rare;
  logic [CNT_W-1:0]  rpt_ones;
  logic [TOT_W-1:0]  rare_total;
  logic              done;
`ifdef RARE_TOGGLE_CNT_EN
  logic [CNT_W-1:0]  rpt_tog;
`endif

  modport master (
    output start, node_valid, nodes,
`ifdef RARE_TOGGLE_CNT_EN
    input  rpt_tog,
`endif
    input  busy, rpt_valid, rpt_idx, rpt_rare, rpt_ones, rare_total, done
  );

  modport slave (
    input  start, node_valid, nodes,
`ifdef RARE_TOGGLE_CNT_EN
    output rpt_tog,
`endif
    output busy, rpt_valid, rpt_idx, rpt_rare, rpt_ones, rare_total, done
  );
endinterface

// File: rtl/rare_node_monitor.sv
// Counts per-node ones over a WINDOW of valid samples, then reports one node per cycle (index k at k+1 cycles after RUN exit).
// No backpressure: samples are taken whenever node_valid is high in RUN. RARE_TOGGLE_CNT_EN adds per-node toggle counting.
module rare_node_monitor #(
  parameter int NODE_W = 16,
  parameter int CNT_W  = 16,
  parameter int WINDOW = 1024,
  parameter int THRESH = 8
) (
  input logic               CK,
  input logic               RST,
  rare_node_monitor_if.slave mon
);
  localparam int IDX_W = (NODE_W > 1) ? $clog2(NODE_W) : 1;
  localparam int TOT_W = $clog2(NODE_W + 1);
  localparam logic [CNT_W:0] WIN_X = (CNT_W+1)'(WINDOW);
  localparam logic [CNT_W:0] THR_X = (CNT_W+1)'(THRESH);

  typedef enum logic [1:0] {IDLE, RUN, SCAN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] ones [NODE_W];
  logic [CNT_W-1:0] smp_cnt;
  logic [IDX_W-1:0] scan_idx;
  logic [TOT_W-1:0] rare_cnt;
  logic [TOT_W-1:0] rare_total_q;
  logic             last_smp, last_idx, cur_rare, rpt_valid;
  logic [CNT_W:0]   cur_ones, cur_zeros, cur_min;
`ifdef RARE_TOGGLE_CNT_EN
  logic [CNT_W-1:0]  tog [NODE_W];
  logic [NODE_W-1:0] prev_nodes;
  logic              first_smp;
`endif

  assign last_smp = (smp_cnt == CNT_W'(WINDOW - 1));
  assign last_idx = (scan_idx == IDX_W'(NODE_W - 1));

  always_ff @(posedge CK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mon.start) state_d = RUN;
      RUN:     if (mon.node_valid && last_smp) state_d = SCAN;
      SCAN:    if (last_idx) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Minority count is taken against WINDOW one bit wider so the subtraction cannot wrap.
  always_comb begin
    cur_ones  = {1'b0, ones[scan_idx]};
    cur_zeros = WIN_X - cur_ones;
    cur_min   = (cur_ones < cur_zeros) ? cur_ones : cur_zeros;
    cur_rare  = (cur_min < THR_X);
`ifdef RARE_TOGGLE_CNT_EN
    if ({1'b0, tog[scan_idx]} < THR_X) cur_rare = 1'b1;
`endif
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NODE_W; i++) ones[i] <= '0;
      smp_cnt      <= '0;
      scan_idx     <= '0;
      rare_cnt     <= '0;
      rare_total_q <= '0;
`ifdef RARE_TOGGLE_CNT_EN
      for (int i = 0; i < NODE_W; i++) tog[i] <= '0;
      prev_nodes <= '0;
      first_smp  <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (mon.start) begin
            for (int i = 0; i < NODE_W; i++) ones[i] <= '0;
            smp_cnt  <= '0;
            scan_idx <= '0;
            rare_cnt <= '0;
`ifdef RARE_TOGGLE_CNT_EN
            for (int i = 0; i < NODE_W; i++) tog[i] <= '0;
            first_smp <= 1'b1;
`endif
          end
        end
        RUN: begin
          if (mon.node_valid) begin
            smp_cnt <= smp_cnt + 1'b1;
            for (int i = 0; i < NODE_W; i++) ones[i] <= ones[i] + CNT_W'(mon.nodes[i]);
`ifdef RARE_TOGGLE_CNT_EN
            // The first sample of a window has no predecessor to compare against.
            for (int i = 0; i < NODE_W; i++)
              if (!first_smp && (mon.nodes[i] != prev_nodes[i])) tog[i] <= tog[i] + 1'b1;
            prev_nodes <= mon.nodes;
            first_smp  <= 1'b0;
`endif
          end
        end
        SCAN: begin
          rare_cnt <= rare_cnt + TOT_W'(cur_rare);
          if (last_idx) begin
            rare_total_q <= rare_cnt + TOT_W'(cur_rare);
            scan_idx     <= '0;
          end else begin
            scan_idx <= scan_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rpt_valid      = (state_q == SCAN);
  assign mon.busy       = (state_q == RUN) || (state_q == SCAN);
  assign mon.done       = (state_q == DONE);
  assign mon.rpt_valid  = rpt_valid;
  assign mon.rpt_idx    = rpt_valid ? scan_idx : '0;
  assign mon.rpt_rare   = rpt_valid & cur_rare;
  assign mon.rpt_ones   = rpt_valid ? ones[scan_idx] : '0;
  assign mon.rare_total = rare_total_q;
`ifdef RARE_TOGGLE_CNT_EN
  assign mon.rpt_tog    = rpt_valid ? tog[scan_idx] : '0;
`endif
endmodule

// File: tb/tb_rare_node_monitor.sv
// Directed bench for rare_node_monitor at NODE_W=4, WINDOW=16, THRESH=2; also builds with RARE_TOGGLE_CNT_EN.
module tb_rare_node_monitor;
  localparam int NODE_W = 4;
  localparam int CNT_W  = 16;
  localparam int WINDOW = 16;
  localparam int THRESH = 2;

  // Window A: nodes=0001 constant. Window B: node0 alternates, node1 high once, node2 high twice, node3 low once.
  localparam logic [3:0][15:0] ONES_A = {16'd0, 16'd0, 16'd0, 16'd16};
  localparam logic [3:0][15:0] ONES_B = {16'd15, 16'd2, 16'd1, 16'd8};
  localparam logic [3:0] RARE_A = 4'b1111;
  localparam int         TOT_A  = 4;
`ifdef RARE_TOGGLE_CNT_EN
  localparam logic [3:0][15:0] TOG_A = {16'd0, 16'd0, 16'd0, 16'd0};
  localparam logic [3:0][15:0] TOG_B = {16'd1, 16'd1, 16'd1, 16'd15};
  localparam logic [3:0] RARE_B = 4'b1110;
  localparam int         TOT_B  = 3;
  logic [3:0][15:0] exp_tog;
`else
  localparam logic [3:0] RARE_B = 4'b1010;
  localparam int         TOT_B  = 2;
`endif

  logic CK  = 1'b0;
  logic RST = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  rare_node_monitor_if #(.NODE_W(NODE_W), .CNT_W(CNT_W)) mif ();

  rare_node_monitor #(.NODE_W(NODE_W), .CNT_W(CNT_W), .WINDOW(WINDOW), .THRESH(THRESH)) dut (
    .CK  (CK),
    .RST (RST),
    .mon (mif.slave)
  );

  always #5 CK = ~CK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic go();
    mif.start = 1'b1;
    tick();
    mif.start = 1'b0;
  endtask

  task automatic feed(input logic [3:0] s);
    mif.nodes      = s;
    mif.node_valid = 1'b1;
    tick();
    mif.node_valid = 1'b0;
    mif.nodes      = 4'h0;
  endtask

  function automatic logic [3:0] smp_b(input int j);
    logic [31:0] jv;
    jv = j;
    return {(j != 0), (j < 2), (j == 0), jv[0]};
  endfunction

  // Called right after the edge carrying the final sample: index 0 must already be on the report bus.
  task automatic check_scan(input string tn, input logic [3:0][15:0] eo, input logic [3:0] er,
                            input int tot, input int prev, input bit spur);
    for (int k = 0; k < 4; k++) begin
      chk({tn, "_vld"},  mif.rpt_valid, 1);
      chk({tn, "_idx"},  mif.rpt_idx, k);
      chk({tn, "_ones"}, mif.rpt_ones, eo[k]);
      chk({tn, "_rare"}, mif.rpt_rare, er[k]);
`ifdef RARE_TOGGLE_CNT_EN
      chk({tn, "_tog"},  mif.rpt_tog, exp_tog[k]);
`endif
      if (k == 0) begin
        chk({tn, "_busy_scan"}, mif.busy, 1);
        chk({tn, "_tot_held"}, mif.rare_total, prev);
      end
      if (spur && k == 1) begin
        mif.start      = 1'b1;
        mif.node_valid = 1'b1;
        mif.nodes      = 4'hF;
      end
      tick();
      mif.start      = 1'b0;
      mif.node_valid = 1'b0;
      mif.nodes      = 4'h0;
    end
    chk({tn, "_done"},      mif.done, 1);
    chk({tn, "_tot"},       mif.rare_total, tot);
    chk({tn, "_busy_done"}, mif.busy, 0);
    chk({tn, "_vld_done"},  mif.rpt_valid, 0);
    tick();
    chk({tn, "_done_once"}, mif.done, 0);
    chk({tn, "_idle"},      mif.busy, 0);
  endtask

  initial begin
    mif.start      = 1'b0;
    mif.node_valid = 1'b0;
    mif.nodes      = 4'h0;
    repeat (3) tick();
    chk("rst_busy", mif.busy, 0);
    chk("rst_vld",  mif.rpt_valid, 0);
    chk("rst_idx",  mif.rpt_idx, 0);
    chk("rst_ones", mif.rpt_ones, 0);
    chk("rst_tot",  mif.rare_total, 0);
    chk("rst_done", mif.done, 0);
    RST = 1'b0;
    tick();

    // Constant stream: every node rare
    go();
    chk("a_busy", mif.busy, 1);
    for (int j = 0; j < WINDOW; j++) begin
      if (j == WINDOW - 1) chk("a_no_early_scan", mif.rpt_valid, 0);
      feed(4'b0001);
    end
`ifdef RARE_TOGGLE_CNT_EN
    exp_tog = TOG_A;
`endif
    check_scan("a", ONES_A, RARE_A, TOT_A, 0, 1'b0);

    // Mixed stream with spurious start in RUN and start/valid during SCAN
    go();
    for (int j = 0; j < WINDOW; j++) begin
      if (j == 5) mif.start = 1'b1;
      feed(smp_b(j));
      mif.start = 1'b0;
    end
`ifdef RARE_TOGGLE_CNT_EN
    exp_tog = TOG_B;
`endif
    check_scan("b", ONES_B, RARE_B, TOT_B, TOT_A, 1'b1);

    // Same stream, valid every other cycle, idle cycles carry junk
    go();
    for (int j = 0; j < WINDOW; j++) begin
      mif.nodes = 4'hF;
      tick();
      if (j == WINDOW - 1) begin
        chk("c_busy_gap", mif.busy, 1);
        chk("c_no_early_scan", mif.rpt_valid, 0);
      end
      feed(smp_b(j));
    end
    check_scan("c", ONES_B, RARE_B, TOT_B, TOT_B, 1'b0);

    // Reset mid-RUN, then start on the first edge after release
    go();
    for (int j = 0; j < 10; j++) feed(4'hF);
    RST = 1'b1;
    #1;
    chk("d_rst_busy", mif.busy, 0);
    chk("d_rst_tot",  mif.rare_total, 0);
    chk("d_rst_vld",  mif.rpt_valid, 0);
    #1;
    RST = 1'b0;
    go();
    chk("d_first_start", mif.busy, 1);
    for (int j = 0; j < WINDOW; j++) feed(4'b0001);
`ifdef RARE_TOGGLE_CNT_EN
    exp_tog = TOG_A;
`endif
    check_scan("d", ONES_A, RARE_A, TOT_A, 0, 1'b0);

    // Reset mid-SCAN drops the partial report
    go();
    for (int j = 0; j < WINDOW; j++) feed(smp_b(j));
    tick();
    tick();
    chk("e_idx2", mif.rpt_idx, 2);
    chk("e_ones2", mif.rpt_ones, 2);
    RST = 1'b1;
    #1;
    chk("e_rst_vld",  mif.rpt_valid, 0);
    chk("e_rst_idx",  mif.rpt_idx, 0);
    chk("e_rst_ones", mif.rpt_ones, 0);
    chk("e_rst_rare", mif.rpt_rare, 0);
    chk("e_rst_busy", mif.busy, 0);
    chk("e_rst_done", mif.done, 0);
    chk("e_rst_tot",  mif.rare_total, 0);
    #1;
    RST = 1'b0;
    go();
    for (int j = 0; j < WINDOW; j++) feed(smp_b(j));
`ifdef RARE_TOGGLE_CNT_EN
    exp_tog = TOG_B;
`endif
    check_scan("e", ONES_B, RARE_B, TOT_B, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
